// File: rtl/scmi_mbox_reg_channels_pkg.sv
// Shared constants for the SCMI register-bus mailbox: window word offsets,
// STATUS bit positions and interrupt mode encoding.
package scmi_mbox_pkg;

  localparam int unsigned STATUS_OFS        = 1;
  localparam int unsigned FLAGS_OFS         = 4;
  localparam int unsigned LENGTH_OFS        = 5;
  localparam int unsigned PAYLOAD_START_OFS = 6;

  localparam int unsigned STATUS_FREE_BIT  = 0;
  localparam int unsigned STATUS_ERROR_BIT = 1;
  localparam int unsigned FLAGS_COMP_IRQ_EN_BIT = 0;

  typedef enum logic {
    IRQ_LEVEL = 1'b0,
    IRQ_PULSE = 1'b1
  } irq_mode_e;

  // Doorbell and completion words sit at the top of every window.
  function automatic int unsigned doorbell_ofs(int unsigned chan_words);
    return chan_words - 2;
  endfunction

  function automatic int unsigned completion_ofs(int unsigned chan_words);
    return chan_words - 1;
  endfunction

endpackage

// File: rtl/scmi_mbox_reg_channels_if.sv
// Register bus (request + response) between the AXI-to-reg bridge and the mailbox.
interface scmi_mbox_reg_channels_if #(
  parameter int unsigned AW = 32
);
  logic          valid;
  logic          write;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          ready;
  logic [31:0]   rdata;
  logic          error;

  modport master (output valid, write, addr, wdata, wstrb, input  ready, rdata, error);
  modport slave  (input  valid, write, addr, wdata, wstrb, output ready, rdata, error);
endinterface

// File: rtl/scmi_mbox_reg_channels_channel.sv
// One SCMI shared-memory channel window: word storage, FREE/ERROR handshake,
// doorbell/completion pending flags and their interrupt outputs.
module scmi_mbox_channel
  import scmi_mbox_pkg::*;
#(
  parameter  int unsigned ChanWords = 32,
  parameter  int unsigned IrqPulse  = 0,
  localparam int unsigned OW        = $clog2(ChanWords)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [OW-1:0] wofs,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  output logic [31:0]   rdata,
  output logic          irq_db,
  output logic          irq_cp
);

  localparam irq_mode_e     MODE        = (IrqPulse != 0) ? IRQ_PULSE : IRQ_LEVEL;
  localparam logic [OW-1:0] O_STATUS    = OW'(STATUS_OFS);
  localparam logic [OW-1:0] O_FLAGS     = OW'(FLAGS_OFS);
  localparam logic [OW-1:0] O_LENGTH    = OW'(LENGTH_OFS);
  localparam logic [OW-1:0] O_PAY_FIRST = OW'(PAYLOAD_START_OFS);
  localparam logic [OW-1:0] O_DOORBELL  = OW'(doorbell_ofs(ChanWords));
  localparam logic [OW-1:0] O_PAY_LAST  = OW'(doorbell_ofs(ChanWords) - 1);
  localparam logic [OW-1:0] O_COMPL     = OW'(completion_ofs(ChanWords));

  logic [31:0] words [ChanWords];
  logic        free, err;
  logic        db_pend, cp_pend;
  logic        db_q, cp_q;
  logic        is_data;

  // Byte-strobed storage: FLAGS, LENGTH and the header/payload area.
  assign is_data = (wofs == O_FLAGS) || (wofs == O_LENGTH) ||
                   ((wofs >= O_PAY_FIRST) && (wofs <= O_PAY_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ChanWords; i++) words[i] <= '0;
      free    <= 1'b1;
      err     <= 1'b0;
      db_pend <= 1'b0;
      cp_pend <= 1'b0;
      db_q    <= 1'b0;
      cp_q    <= 1'b0;
    end else begin
      db_q <= db_pend;
      cp_q <= cp_pend;
      if (we) begin
        if (wofs == O_STATUS) begin
          if (wstrb[0]) begin
            free <= wdata[STATUS_FREE_BIT];
            err  <= wdata[STATUS_ERROR_BIT];
          end
        end else if (wofs == O_DOORBELL) begin
          if (wstrb[0]) begin
            db_pend <= wdata[0];
            if (wdata[0]) free <= 1'b0;
          end
        end else if (wofs == O_COMPL) begin
          if (wstrb[0]) begin
            if (wdata[0]) begin
              free <= 1'b1;
              // Without COMP_IRQ_EN the agent polls FREE; no completion pending.
              if (words[O_FLAGS][FLAGS_COMP_IRQ_EN_BIT]) cp_pend <= 1'b1;
            end else begin
              cp_pend <= 1'b0;
            end
          end
        end else if (is_data) begin
          for (int b = 0; b < 4; b++)
            if (wstrb[b]) words[wofs][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (wofs == O_STATUS) begin
      rdata[STATUS_FREE_BIT]  = free;
      rdata[STATUS_ERROR_BIT] = err;
    end else if (wofs == O_DOORBELL) begin
      rdata[0] = db_pend;
    end else if (wofs == O_COMPL) begin
      rdata[0] = cp_pend;
    end else if (is_data) begin
      rdata = words[wofs];
    end
  end

  // Pulse mode fires only on a 0->1 edge of PEND, so re-ringing stays silent.
  assign irq_db = (MODE == IRQ_PULSE) ? (db_pend & ~db_q) : db_pend;
  assign irq_cp = (MODE == IRQ_PULSE) ? (cp_pend & ~cp_q) : cp_pend;

endmodule

// File: rtl/scmi_mbox_reg_channels.sv
// SCMI shared-memory mailbox on the register bus: address decode, per-channel
// windows and the read mux / error response.
module scmi_mbox_reg_channels
  import scmi_mbox_pkg::*;
#(
  parameter int unsigned NumChannels = 4,
  parameter int unsigned ChanWords   = 32,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned IrqPulse    = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  scmi_mbox_reg_channels_if.slave    reg_bus,
  output logic [NumChannels-1:0]     irq_doorbell_o,
  output logic [NumChannels-1:0]     irq_completion_o
);

  localparam int unsigned OW  = $clog2(ChanWords);
  localparam int unsigned CSW = (NumChannels > 1) ? $clog2(NumChannels) : 1;

  logic [OW-1:0]                   wofs;
  logic [AddrWidth-1:0]            ch_full;
  logic [CSW-1:0]                  ch;
  logic                            hit;
  logic [NumChannels-1:0]          we;
  logic [NumChannels-1:0][31:0]    ch_rdata;

  assign wofs    = reg_bus.addr[OW+1:2];
  assign ch_full = reg_bus.addr >> (OW + 2);
  assign ch      = ch_full[CSW-1:0];
  assign hit     = (reg_bus.addr[1:0] == 2'b00) && (ch_full < AddrWidth'(NumChannels));

  assign reg_bus.ready = reg_bus.valid;
  assign reg_bus.error = reg_bus.valid & ~hit;
  assign reg_bus.rdata = (reg_bus.valid && hit && !reg_bus.write) ? ch_rdata[ch] : '0;

  for (genvar i = 0; i < NumChannels; i++) begin : g_chan
    assign we[i] = reg_bus.valid & reg_bus.write & hit & (ch == CSW'(i));

    scmi_mbox_channel #(
      .ChanWords (ChanWords),
      .IrqPulse  (IrqPulse)
    ) u_chan (
      .clk    (clk_i),
      .rst_n  (rst_ni),
      .we     (we[i]),
      .wofs   (wofs),
      .wdata  (reg_bus.wdata),
      .wstrb  (reg_bus.wstrb),
      .rdata  (ch_rdata[i]),
      .irq_db (irq_doorbell_o[i]),
      .irq_cp (irq_completion_o[i])
    );
  end

endmodule
